// File: rtl/filtro_erosion_3x3.sv
// filtro_erosion_3x3: streaming 3x3 grayscale erosion (window minimum).
// Each accepted column carries three vertically adjacent pixels. The block
// reduces the column to its minimum, keeps the two previous column minima,
// and emits the minimum of the 3x3 window once three columns of the current
// row have been seen. A row of W columns therefore yields W-2 outputs.
//
// Handshake: a beat moves across an interface in a cycle where its valid and
// ready are both 1 at the rising edge. Upstream: entrada_valida/entrada_lista.
// Downstream: salida_valida/salida_lista. Once salida_valida rises, menor and
// salida_fin_fila hold until the beat is taken. entrada_lista is purely
// combinational from the output register state, so a new column is taken
// only when the output slot is empty or is being emptied in the same cycle.
//
// estado exposes the fill state machine for observation.
module filtro_erosion_3x3 #(
  parameter int BITS_NUMERO = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BITS_NUMERO-1:0] pixel_arriba,
  input  logic [BITS_NUMERO-1:0] pixel_centro,
  input  logic [BITS_NUMERO-1:0] pixel_abajo,
  input  logic                   inicio_fila,
  input  logic                   fin_fila,
  input  logic                   entrada_valida,
  output logic                   entrada_lista,
  output logic [BITS_NUMERO-1:0] menor,
  output logic                   salida_fin_fila,
  output logic                   salida_valida,
  input  logic                   salida_lista,
  output logic [1:0]             estado
);

  // Fill level of the current row: how many columns the history holds.
  typedef enum logic [1:0] {
    ESPERA     = 2'd0,
    LLENANDO_1 = 2'd1,
    LLENANDO_2 = 2'd2,
    ACTIVO     = 2'd3
  } estado_t;

  estado_t                state_q;
  estado_t                state_d;
  logic [BITS_NUMERO-1:0] col0_q;
  logic [BITS_NUMERO-1:0] col1_q;
  logic [BITS_NUMERO-1:0] col0_d;
  logic [BITS_NUMERO-1:0] col1_d;
  logic [BITS_NUMERO-1:0] min_ac;
  logic [BITS_NUMERO-1:0] col_min;
  logic [BITS_NUMERO-1:0] win_tmp;
  logic [BITS_NUMERO-1:0] win_min;
  logic                   transfer;
  logic                   cargar;

  // Upstream ready: the output slot is empty or is drained this cycle.
  always_comb begin
    entrada_lista = !salida_valida || salida_lista;
    transfer      = entrada_valida && entrada_lista;
  end

  // Unsigned minimum of the incoming column, then of the whole window.
  always_comb begin
    min_ac  = (pixel_arriba < pixel_centro) ? pixel_arriba : pixel_centro;
    col_min = (min_ac < pixel_abajo) ? min_ac : pixel_abajo;
    win_tmp = (col_min < col0_q) ? col_min : col0_q;
    win_min = (win_tmp < col1_q) ? win_tmp : col1_q;
  end

  // Next fill state, history update and output-load decision.
  always_comb begin
    state_d = state_q;
    col0_d  = col0_q;
    col1_d  = col1_q;
    cargar  = 1'b0;
    if (transfer) begin
      if (inicio_fila || (state_q == ESPERA)) begin
        // Row start (explicit, or implied after reset / end of row):
        // the history holds only this column.
        col0_d  = col_min;
        col1_d  = '0;
        state_d = fin_fila ? ESPERA : LLENANDO_1;
      end else begin
        col1_d = col0_q;
        col0_d = col_min;
        case (state_q)
          LLENANDO_1: begin
            state_d = fin_fila ? ESPERA : LLENANDO_2;
          end
          LLENANDO_2, ACTIVO: begin
            cargar  = 1'b1;
            state_d = fin_fila ? ESPERA : ACTIVO;
          end
          default: begin
            state_d = ESPERA;
          end
        endcase
      end
    end
  end

  // Fill state and column-minimum history registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ESPERA;
      col0_q  <= '0;
      col1_q  <= '0;
    end else begin
      state_q <= state_d;
      col0_q  <= col0_d;
      col1_q  <= col1_d;
    end
  end

  // Output register: load a new window, drain on acceptance, else hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      menor           <= '0;
      salida_fin_fila <= 1'b0;
      salida_valida   <= 1'b0;
    end else if (cargar) begin
      menor           <= win_min;
      salida_fin_fila <= fin_fila;
      salida_valida   <= 1'b1;
    end else if (salida_valida && salida_lista) begin
      salida_valida   <= 1'b0;
    end
  end

  // Debug view of the fill state.
  always_comb begin
    estado = state_q;
  end

endmodule

// File: tb/tb_filtro_erosion_3x3.sv
// tb_filtro_erosion_3x3: scoreboard bench for the 3x3 erosion block.
// The reference model keeps the column minima of the current row in a queue
// and, per accepted column, predicts the window minimum of the last three.
module tb_filtro_erosion_3x3;
  localparam int B = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b0;
  logic [B-1:0] pixel_arriba = '0;
  logic [B-1:0] pixel_centro = '0;
  logic [B-1:0] pixel_abajo = '0;
  logic         inicio_fila = 1'b0;
  logic         fin_fila = 1'b0;
  logic         entrada_valida = 1'b0;
  logic         entrada_lista;
  logic [B-1:0] menor;
  logic         salida_fin_fila;
  logic         salida_valida;
  logic         salida_lista;
  logic [1:0]   estado;

  filtro_erosion_3x3 #(.BITS_NUMERO(B)) dut (
    .clk(clk),
    .reset(reset),
    .pixel_arriba(pixel_arriba),
    .pixel_centro(pixel_centro),
    .pixel_abajo(pixel_abajo),
    .inicio_fila(inicio_fila),
    .fin_fila(fin_fila),
    .entrada_valida(entrada_valida),
    .entrada_lista(entrada_lista),
    .menor(menor),
    .salida_fin_fila(salida_fin_fila),
    .salida_valida(salida_valida),
    .salida_lista(salida_lista),
    .estado(estado)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // ---------------- scoreboard state ----------------
  logic [B:0] exp_q[$];          // {fin, window min}
  typedef struct {
    int         cycle;
    bit         prod;
    logic [B-1:0] val;
    bit         fin;
  } lat_t;
  lat_t lat_q[$];
  int   row_q[$];
  bit   row_open = 1'b0;
  int   lista_mode = 0;          // 0: always ready, 1: random, 2: stalled

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int min3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  // Reference model: row of column minima, window over the last three.
  task automatic model_accept(input int m, input bit ini, input bit fin);
    lat_t l;
    int   n;
    int   w;
    if (ini || !row_open) begin
      row_q.delete();
      row_open = 1'b1;
    end
    row_q.push_back(m);
    n = row_q.size();
    l.cycle = cyc;
    l.prod  = 1'b0;
    l.val   = '0;
    l.fin   = fin;
    if (n >= 3) begin
      w = min3(row_q[n-1], row_q[n-2], row_q[n-3]);
      exp_q.push_back({fin, w[B-1:0]});
      l.prod = 1'b1;
      l.val  = w[B-1:0];
    end
    lat_q.push_back(l);
    if (fin) begin
      row_open = 1'b0;
      row_q.delete();
    end
  endtask

  // ---------------- downstream ready driver ----------------
  initial begin
    salida_lista = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (lista_mode)
        0:       salida_lista = 1'b1;
        1:       salida_lista = ($urandom_range(0, 3) != 0);
        default: salida_lista = 1'b0;
      endcase
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send_col(input logic [B-1:0] a, input logic [B-1:0] c,
                          input logic [B-1:0] b, input bit ini, input bit fin);
    bit accepted;
    accepted       = 1'b0;
    pixel_arriba   = a;
    pixel_centro   = c;
    pixel_abajo    = b;
    inicio_fila    = ini;
    fin_fila       = fin;
    entrada_valida = 1'b1;
    for (int i = 0; i < 100 && !accepted; i++) begin
      @(negedge clk);
      if (entrada_lista) begin
        model_accept(min3(int'(a), int'(c), int'(b)), ini, fin);
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) chk("accept_timeout", 0, 1);
    entrada_valida = 1'b0;
  endtask

  // Column whose minimum is m, placed at a random row position.
  task automatic send_min(input int m, input bit ini, input bit fin);
    logic [B-1:0] p[3];
    int pos;
    pos = $urandom_range(0, 2);
    for (int k = 0; k < 3; k++) p[k] = (k == pos) ? m[B-1:0] : B'($urandom_range(m, 255));
    send_col(p[0], p[1], p[2], ini, fin);
  endtask

  task automatic idle(input int n);
    entrada_valida = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    exp_q.delete();
    row_q.delete();
    row_open = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
  endtask

  // ---------------- monitor ----------------
  bit           held_armed = 1'b0;
  logic [B-1:0] held_m;
  logic         held_f;

  always @(negedge clk) begin
    logic [B:0] e;
    lat_t l;
    if (reset) begin
      if (salida_valida && !salida_lista) chk("stall_ready", entrada_lista, 0);
      else chk("ready", entrada_lista, 1);
      if (held_armed) begin
        chk("hold_valid", salida_valida, 1);
        chk("hold_menor", menor, held_m);
        chk("hold_fin", salida_fin_fila, held_f);
      end
      held_armed = salida_valida && !salida_lista;
      held_m     = menor;
      held_f     = salida_fin_fila;
      if (salida_valida && salida_lista) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("menor", menor, e[B-1:0]);
          chk("fin_fila", salida_fin_fila, e[B]);
        end
      end
    end else begin
      held_armed = 1'b0;
    end
    // Output must appear exactly one cycle after its column (and only then).
    while (lat_q.size() > 0 && lat_q[0].cycle + 1 < cyc) void'(lat_q.pop_front());
    if (lat_q.size() > 0 && lat_q[0].cycle + 1 == cyc) begin
      l = lat_q.pop_front();
      chk("lat_valid", salida_valida, l.prod);
      if (l.prod) begin
        chk("lat_menor", menor, l.val);
        chk("lat_fin", salida_fin_fila, l.fin);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int len;
    bit ini;
    bit fin;
    @(posedge clk);
    #1;
    do_reset(3);
    chk("rst_valid", salida_valida, 0);
    chk("rst_menor", menor, 0);
    chk("rst_fin", salida_fin_fila, 0);
    chk("rst_ready", entrada_lista, 1);
    chk("rst_estado", estado, 0);

    // Row of five columns with minima 9,4,7,2,8 -> 4,2,2.
    send_min(9, 1, 0);
    send_min(4, 0, 0);
    send_min(7, 0, 0);
    send_min(2, 0, 0);
    send_min(8, 0, 1);
    idle(2);

    // Unsigned compare: 200 must not look negative.
    send_col(8'd200, 8'd3, 8'd90, 1, 0);
    send_col(8'd250, 8'd250, 8'd250, 0, 0);
    send_col(8'd100, 8'd200, 8'd255, 0, 1);
    idle(2);

    // Downstream stall of about four cycles while a window is held.
    lista_mode = 2;
    send_min(50, 1, 0);
    send_min(40, 0, 0);
    send_min(60, 0, 0);
    fork
      send_min(30, 0, 0);
      begin
        repeat (2) @(negedge clk);
        chk("stall_dir_ready", entrada_lista, 0);
        chk("stall_dir_menor", menor, 40);
        repeat (2) @(posedge clk);
        lista_mode = 0;
      end
    join
    send_min(70, 0, 0);
    send_min(80, 0, 1);
    idle(3);

    // Mid-row restart on the 4th column.
    send_min(5, 1, 0);
    send_min(6, 0, 0);
    send_min(7, 0, 0);
    send_min(1, 1, 0);
    send_min(9, 0, 0);
    send_min(12, 0, 0);
    send_min(11, 0, 1);
    idle(2);

    // Reset after three columns, then 10,10,10 without an explicit row start.
    send_min(20, 1, 0);
    send_min(21, 0, 0);
    send_min(22, 0, 0);
    do_reset(1);
    chk("midrst_valid", salida_valida, 0);
    chk("midrst_menor", menor, 0);
    chk("midrst_estado", estado, 0);
    send_col(8'd10, 8'd10, 8'd10, 0, 0);
    send_col(8'd10, 8'd10, 8'd10, 0, 0);
    send_col(8'd10, 8'd10, 8'd10, 0, 1);
    idle(2);

    // Two columns in flight, then a one-column row.
    send_min(33, 1, 0);
    send_min(34, 0, 0);
    chk("fill2_estado", estado, 2);
    send_min(35, 1, 1);
    chk("onecol_estado", estado, 0);
    idle(2);

    // Randomized rows with gaps, dropped markers and random backpressure.
    lista_mode = 1;
    for (int r = 0; r < 40; r++) begin
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) begin
        ini = (k == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
        fin = (k == len - 1) ? ($urandom_range(0, 9) != 0) : 1'b0;
        send_col(B'($urandom_range(0, 255)), B'($urandom_range(0, 255)),
                 B'($urandom_range(0, 255)), ini, fin);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end

    lista_mode = 0;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
    idle(2);
    chk("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
